// File: rtl/led_pkg.sv
// Shared types and constants for the four-LED pattern sequencer.
package led_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_CHASE  = 3'd1,
      ST_BOUNCE = 3'd2,
      ST_BLINK  = 3'd3,
      ST_COUNT  = 3'd4
   } state_e;

   localparam logic [1:0] PAT_CHASE  = 2'b00;
   localparam logic [1:0] PAT_BOUNCE = 2'b01;
   localparam logic [1:0] PAT_BLINK  = 2'b10;
   localparam logic [1:0] PAT_COUNT  = 2'b11;

   localparam logic [3:0] INIT_CHASE  = 4'b0001;
   localparam logic [3:0] INIT_BOUNCE = 4'b0001;
   localparam logic [3:0] INIT_BLINK  = 4'b0000;
   localparam logic [3:0] INIT_COUNT  = 4'b0000;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   function automatic state_e pat2state(input logic [1:0] p);
      state_e s;
      unique case (p)
         PAT_CHASE:  s = ST_CHASE;
         PAT_BOUNCE: s = ST_BOUNCE;
         PAT_BLINK:  s = ST_BLINK;
         default:    s = ST_COUNT;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] pat_init(input logic [1:0] p);
      logic [3:0] v;
      unique case (p)
         PAT_CHASE:  v = INIT_CHASE;
         PAT_BOUNCE: v = INIT_BOUNCE;
         PAT_BLINK:  v = INIT_BLINK;
         default:    v = INIT_COUNT;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: pulses tick once per limit_i cycles while not cleared.
module led_tick_gen
   import led_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic [31:0] limit_i,
   output logic        tick_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // >= lets a shrinking limit fire at once instead of wrapping the counter
   assign tick_o = (cnt_q >= (limit_i - 32'd1));

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: switch synchronizer plus pattern state machine.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int unsigned TICK_CNT = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   output logic [3:0] led,
   output logic       step
);

   logic [3:0]  sw_meta_q;
   logic [3:0]  sw_s_q;
   state_e      state_q;
   logic [3:0]  led_q;
   logic        step_q;
   logic        dir_q;
   logic [31:0] limit;
   logic        tick;
   logic        clr;
   logic        en;
   logic        fast;
   logic [1:0]  pat;
   state_e      pat_st;

   assign en     = sw_s_q[0];
   assign pat    = sw_s_q[2:1];
   assign fast   = sw_s_q[3];
   assign pat_st = pat2state(pat);
   assign limit  = fast ? (TICK_CNT >> 1) : TICK_CNT;
   assign clr    = (state_q == ST_OFF) || !en;

   led_tick_gen u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .limit_i (limit),
      .tick_o  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_s_q    <= '0;
         state_q   <= ST_OFF;
         led_q     <= '0;
         step_q    <= 1'b0;
         dir_q     <= DIR_UP;
      end else begin
         sw_meta_q <= sw;
         sw_s_q    <= sw_meta_q;
         step_q    <= 1'b0;
         if (state_q == ST_OFF) begin
            led_q <= '0;
            if (en) begin
               state_q <= pat_st;
               led_q   <= pat_init(pat);
               dir_q   <= DIR_UP;
            end
         end else if (!en) begin
            state_q <= ST_OFF;
            led_q   <= '0;
         end else if (tick) begin
            step_q <= 1'b1;
            // a new selection is only taken on a step boundary
            if (state_q != pat_st) begin
               state_q <= pat_st;
               led_q   <= pat_init(pat);
               dir_q   <= DIR_UP;
            end else begin
               case (state_q)
                  ST_CHASE:  led_q <= {led_q[2:0], led_q[3]};
                  ST_BOUNCE: begin
                     if (dir_q == DIR_UP) begin
                        led_q <= led_q << 1;
                        if (led_q == 4'b0100) dir_q <= DIR_DOWN;
                     end else begin
                        led_q <= led_q >> 1;
                        if (led_q == 4'b0010) dir_q <= DIR_UP;
                     end
                  end
                  ST_BLINK:  led_q <= ~led_q;
                  ST_COUNT:  led_q <= led_q + 4'd1;
                  default:   led_q <= '0;
               endcase
            end
         end
      end
   end

   assign led  = led_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random switch traffic.
module tb_led_pattern_ctrl;

   localparam int TICK = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw = 4'b0000;
   logic [3:0] led;
   logic       step;

   int checks = 0;
   int failures = 0;

   led_pattern_ctrl #(.TICK_CNT(TICK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw),
      .led   (led),
      .step  (step)
   );

   always #5 clk = ~clk;

   // reference model: pattern index k into each pattern's sequence
   logic [3:0] bseq [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
   logic [3:0] m_s1, m_s2;
   bit         m_active;
   logic [1:0] m_pat;
   int         m_k;
   int         m_cnt;
   bit         m_step;

   function automatic logic [3:0] model_led();
      logic [3:0] v;
      v = 4'h0;
      if (m_active) begin
         case (m_pat)
            2'b00: v = 4'(1 << (m_k % 4));
            2'b01: v = bseq[m_k % 6];
            2'b10: v = (m_k % 2) ? 4'hF : 4'h0;
            default: v = 4'(m_k % 16);
         endcase
      end
      return v;
   endfunction

   task automatic cyc();
      logic [3:0] s;
      int lim;
      @(posedge clk);
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_active = 0;
         m_cnt = 0; m_step = 0; m_k = 0; m_pat = 0;
      end else begin
         s = m_s2;
         m_s2 = m_s1;
         m_s1 = sw;
         m_step = 0;
         if (!m_active) begin
            if (s[0]) begin
               m_active = 1; m_pat = s[2:1]; m_k = 0; m_cnt = 0;
            end
         end else if (!s[0]) begin
            m_active = 0; m_cnt = 0;
         end else begin
            lim = s[3] ? TICK / 2 : TICK;
            if (m_cnt + 1 >= lim) begin
               m_step = 1; m_cnt = 0;
               if (s[2:1] == m_pat) m_k++;
               else begin m_pat = s[2:1]; m_k = 0; end
            end else begin
               m_cnt++;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sw = 4'b0000;
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   task automatic wait_step(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (step === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sw = 4'b0001;
      repeat (3) cyc();
      checks++;
      if ({step, led} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold got step=%b led=%b want 0 0000", step, led);
      end
      rst_n = 1'b1;
      repeat (3) cyc();
      checks++;
      if (led !== 4'b0001) begin
         failures++;
         $display("FAIL reset_init got led=%b want 0001", led);
      end
      for (int i = 1; i <= TICK; i++) begin
         cyc();
         checks++;
         if ({step, led} !== {m_step, model_led()}) begin
            failures++;
            $display("FAIL reset_model c=%0d got %b/%b want %b/%b",
                     i, step, led, m_step, model_led());
         end
      end
      checks++;
      if ({step, led} !== 5'b1_0010) begin
         failures++;
         $display("FAIL reset_first_step got step=%b led=%b want 1 0010", step, led);
      end
   endtask

   task automatic test_chase();
      logic [3:0] exp [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
      int n;
      do_reset();
      sw = 4'b0001;
      repeat (3) cyc();
      for (int i = 0; i < 4; i++) begin
         wait_step(n);
         checks++;
         if (n !== TICK || led !== exp[i]) begin
            failures++;
            $display("FAIL chase_step%0d got n=%0d led=%b want n=%0d led=%b",
                     i, n, led, TICK, exp[i]);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp [7] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
      int n;
      do_reset();
      sw = 4'b0011;
      repeat (3) cyc();
      checks++;
      if (led !== 4'b0001) begin
         failures++;
         $display("FAIL bounce_init got led=%b want 0001", led);
      end
      for (int i = 0; i < 7; i++) begin
         wait_step(n);
         checks++;
         if (n !== TICK || led !== exp[i]) begin
            failures++;
            $display("FAIL bounce_step%0d got n=%0d led=%b want n=%0d led=%b",
                     i, n, led, TICK, exp[i]);
         end
      end
   endtask

   task automatic test_blink_fast();
      int n;
      logic [3:0] e;
      do_reset();
      sw = 4'b1101;
      repeat (3) cyc();
      e = 4'h0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) sw = 4'b0101;
         wait_step(n);
         e = ~e;
         checks++;
         if (n !== ((i < 4) ? TICK / 2 : TICK) || led !== e) begin
            failures++;
            $display("FAIL blink_step%0d got n=%0d led=%b want n=%0d led=%b",
                     i, n, led, (i < 4) ? TICK / 2 : TICK, e);
         end
      end
   endtask

   task automatic test_pattern_change();
      int n;
      do_reset();
      sw = 4'b0001;
      repeat (3) cyc();
      wait_step(n);
      wait_step(n);
      repeat (3) cyc();
      sw = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if ({step, led} !== 5'b0_0100) begin
            failures++;
            $display("FAIL chg_hold%0d got step=%b led=%b want 0 0100", i, step, led);
         end
      end
      cyc();
      checks++;
      if ({step, led} !== 5'b1_0000) begin
         failures++;
         $display("FAIL chg_switch got step=%b led=%b want 1 0000", step, led);
      end
      wait_step(n);
      checks++;
      if (n !== TICK || led !== 4'b0001) begin
         failures++;
         $display("FAIL chg_next got n=%0d led=%b want n=%0d led=0001", n, led, TICK);
      end
   endtask

   task automatic test_disable();
      int n;
      do_reset();
      sw = 4'b0111;
      repeat (3) cyc();
      repeat (5) wait_step(n);
      checks++;
      if (led !== 4'b0101) begin
         failures++;
         $display("FAIL dis_pre got led=%b want 0101", led);
      end
      repeat (5) cyc();
      sw = 4'b0110;
      repeat (2) cyc();
      checks++;
      if ({step, led} !== 5'b0_0101) begin
         failures++;
         $display("FAIL dis_lag got step=%b led=%b want 0 0101", step, led);
      end
      cyc();
      checks++;
      if ({step, led} !== 5'b0_0000) begin
         failures++;
         $display("FAIL dis_off got step=%b led=%b want 0 0000", step, led);
      end
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if ({step, led} !== 5'b0_0000) begin
            failures++;
            $display("FAIL dis_idle%0d got step=%b led=%b want 0 0000", i, step, led);
         end
      end
      sw = 4'b0111;
      repeat (3) cyc();
      wait_step(n);
      checks++;
      if (n !== TICK || led !== 4'b0001) begin
         failures++;
         $display("FAIL reen_step got n=%0d led=%b want n=%0d led=0001", n, led, TICK);
      end
   endtask

   task automatic test_random();
      int hold;
      do_reset();
      for (int seg = 0; seg < 300; seg++) begin
         sw = 4'($urandom);
         rst_n = ($urandom_range(0, 39) != 0);
         hold = $urandom_range(1, 20);
         for (int i = 0; i < hold; i++) begin
            cyc();
            rst_n = 1'b1;
            checks++;
            if ({step, led} !== {m_step, model_led()}) begin
               failures++;
               $display("FAIL random seg=%0d c=%0d sw=%b got %b/%b want %b/%b",
                        seg, i, sw, step, led, m_step, model_led());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_chase();
      test_bounce();
      test_blink_fast();
      test_pattern_change();
      test_disable();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
